// File: rtl/dm_access_unit_pkg.sv
// Shared data-memory command encodings, FSM states and access-size helpers
// used by the MEM-stage access unit and the control unit's DMOp decoder.
package dm_access_unit_pkg;

  typedef enum logic [2:0] {
    DM_W   = 3'd0,
    DM_LB  = 3'd1,
    DM_LBU = 3'd2,
    DM_LH  = 3'd3,
    DM_LHU = 3'd4,
    DM_SB  = 3'd5,
    DM_SH  = 3'd6
  } dm_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Unknown encodings fall back to a full word access.
  function automatic size_e op_size(input logic [2:0] op);
    case (op)
      DM_LB, DM_LBU, DM_SB: op_size = SZ_BYTE;
      DM_LH, DM_LHU, DM_SH: op_size = SZ_HALF;
      default:              op_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] lane);
    case (op_size(op))
      SZ_WORD: is_aligned = (lane == 2'b00);
      SZ_HALF: is_aligned = (lane[0] == 1'b0);
      default: is_aligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] op, input logic [1:0] lane);
    case (op_size(op))
      SZ_WORD: byte_enables = 4'b1111;
      SZ_HALF: byte_enables = lane[1] ? 4'b1100 : 4'b0011;
      default: byte_enables = 4'b0001 << lane;
    endcase
  endfunction

endpackage

// File: rtl/dm_access_unit_load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it;
// purely combinational so a future cache can share it.
module load_extend
  import dm_access_unit_pkg::*;
(
  input  logic [31:0] bus_rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  dm_op,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = bus_rdata[8*lane +: 8];
    half_sel = bus_rdata[16*lane[1] +: 16];
    case (dm_op)
      DM_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
      DM_LBU:  ext = {24'd0, byte_sel};
      DM_LH:   ext = {{16{half_sel[15]}}, half_sel};
      DM_LHU:  ext = {16'd0, half_sel};
      default: ext = bus_rdata;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// MEM-stage data-memory responder: one word-aligned bus transaction per load or
// store, with pipeline stall until ack or timeout, and extended load results.
module dm_access_unit
  import dm_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        mem_write,
  input  logic [2:0]  dm_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        addr_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  state_e           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       op_reg;
  logic [1:0]       lane_reg;
  logic             aligned;
  size_e            size;
  logic [31:0]      lane_wdata;
  logic [31:0]      ext_data;

  assign aligned = is_aligned(dm_op, addr[1:0]);
  assign size    = op_size(dm_op);

  // Replicate store data onto every byte lane so the slave can pick by bus_be.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_wdata[gi*8 +: 8] = (size == SZ_WORD) ? wdata[gi*8 +: 8] :
                                     (size == SZ_HALF) ? wdata[(gi%2)*8 +: 8] :
                                                         wdata[7:0];
    end
  endgenerate

  load_extend u_load_extend (
    .bus_rdata (bus_rdata),
    .lane      (lane_reg),
    .dm_op     (op_reg),
    .ext       (ext_data)
  );

  assign stall = !reset && ((state_reg == ST_BUS) ||
                            (state_reg == ST_IDLE && req_valid && aligned));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      op_reg      <= 3'd0;
      lane_reg    <= 2'd0;
      rdata       <= 32'd0;
      rdata_valid <= 1'b0;
      addr_err    <= 1'b0;
      bus_err     <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= 32'd0;
      bus_be      <= 4'd0;
      bus_wdata   <= 32'd0;
    end else begin
      rdata_valid <= 1'b0;
      addr_err    <= 1'b0;
      bus_err     <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid && !aligned) begin
            addr_err <= 1'b1;
          end else if (req_valid) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= byte_enables(dm_op, addr[1:0]);
            bus_wdata <= lane_wdata;
            op_reg    <= dm_op;
            lane_reg  <= addr[1:0];
            cnt_reg   <= '0;
            state_reg <= ST_BUS;
          end
        end
        ST_BUS: begin
          // Ack is tested first so it wins over a coincident timeout.
          if (bus_ack || cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            if (bus_ack && !bus_we) begin
              rdata       <= ext_data;
              rdata_valid <= 1'b1;
            end
            bus_err   <= !bus_ack;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
            state_reg <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
